// File: rtl/up_axi_lite_bridge.sv
// AXI4-Lite slave bridging one transaction at a time onto the up_* register bus.
// Accept -> 1-cycle up_*req -> wait for ack (bounded by TIMEOUT_CYCLES) -> AXI response.
module up_axi_lite_bridge #(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,

    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [1:0]                   s_axi_rresp,
    output logic [31:0]                  s_axi_rdata,

    output logic                         up_wreq,
    output logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    output logic [31:0]                  up_wdata,
    input  logic                         up_wack,
    output logic                         up_rreq,
    output logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    input  logic [31:0]                  up_rdata,
    input  logic                         up_rack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WREQ, WWAIT, WRESP, RREQ, RWAIT, RRESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last_wr;
    logic          w_elig, r_elig, w_win, r_win, timeout;
    logic          unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Round-robin: when both directions are eligible, write wins unless it completed last.
    assign w_elig  = s_axi_awvalid & s_axi_wvalid;
    assign r_elig  = s_axi_arvalid;
    assign w_win   = w_elig & (~r_elig | ~last_wr);
    assign r_win   = r_elig & ~w_win;
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (w_win) state_nxt = WREQ;
                     else if (r_win) state_nxt = RREQ;
            WREQ:    state_nxt = WWAIT;
            WWAIT:   if (up_wack || timeout) state_nxt = WRESP;
            WRESP:   if (s_axi_bready) state_nxt = IDLE;
            RREQ:    state_nxt = RWAIT;
            RWAIT:   if (up_rack || timeout) state_nxt = RRESP;
            RRESP:   if (s_axi_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        up_wreq       = 1'b0;
        up_rreq       = 1'b0;
        case (state)
            IDLE: begin
                s_axi_awready = w_win;
                s_axi_wready  = w_win;
                s_axi_arready = r_win;
            end
            WREQ:    up_wreq      = 1'b1;
            WRESP:   s_axi_bvalid = 1'b1;
            RREQ:    up_rreq      = 1'b1;
            RRESP:   s_axi_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_waddr    <= '0;
            up_wdata    <= '0;
            up_raddr    <= '0;
            cnt         <= '0;
            last_wr     <= 1'b0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
        end else begin
            if (state == IDLE && w_win) begin
                up_waddr <= s_axi_awaddr[AXI_ADDRESS_WIDTH-1:2];
                up_wdata <= s_axi_wdata;
            end
            if (state == IDLE && r_win)
                up_raddr <= s_axi_araddr[AXI_ADDRESS_WIDTH-1:2];

            if (state == WREQ || state == RREQ)
                cnt <= '0;
            else if ((state == WWAIT || state == RWAIT) && cnt != '1)
                cnt <= cnt + CW'(1);

            if (state == WWAIT) begin
                if (up_wack)      s_axi_bresp <= 2'b00;
                else if (timeout) s_axi_bresp <= 2'b10;
            end
            // Read data is captured in the ack cycle; a timeout substitutes a marker word.
            if (state == RWAIT) begin
                if (up_rack) begin
                    s_axi_rresp <= 2'b00;
                    s_axi_rdata <= up_rdata;
                end else if (timeout) begin
                    s_axi_rresp <= 2'b10;
                    s_axi_rdata <= 32'hDEAD_DEAD;
                end
            end

            if (state == WRESP && s_axi_bready) last_wr <= 1'b1;
            if (state == RRESP && s_axi_rready) last_wr <= 1'b0;
        end
    end

endmodule
